// File: rtl/cnt_pkg.sv
// Shared definitions for the loadable down-counter timer: FSM state encoding
// and default datapath parameters.
package cnt_pkg;

    localparam int CNT_WIDTH          = 8;
    localparam int CNT_RELOAD_DEFAULT = 255;

    // Encoding 2'd3 is unused and recovers to ST_IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_cnt_core.sv
// Datapath of the down-counter timer: count register, reload register and the
// load / reload / decrement mux. Control strobes come from the FSM in the top.
module down_cnt_core
    import cnt_pkg::*;
#(
    parameter int WIDTH          = CNT_WIDTH,
    parameter int RELOAD_DEFAULT = CNT_RELOAD_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_reload,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] RELOAD_INIT = WIDTH'(RELOAD_DEFAULT);

    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reload <= RELOAD_INIT;
        end else if (i_load) begin
            r_reload <= i_data;
        end
    end

    // Load beats reload beats decrement; the FSM never asserts reload and
    // decrement together, but the order keeps the mux well defined.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_data;
        end else if (i_reload) begin
            r_count <= r_reload;
        end else if (i_dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/down_cnt_timer.sv
// Loadable down-counter timer with borrow pulse, one-shot / auto-reload modes
// and an IDLE/RUN/DONE control FSM around the down_cnt_core datapath.
module down_cnt_timer
    import cnt_pkg::*;
#(
    parameter int WIDTH          = CNT_WIDTH,
    parameter int RELOAD_DEFAULT = CNT_RELOAD_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_bout,
    output logic             o_zero,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_bout;
    logic             w_bout_next;
    logic             w_reload;
    logic             w_dec;
    logic             w_zero;
    logic [WIDTH-1:0] w_count;

    down_cnt_core #(
        .WIDTH          (WIDTH),
        .RELOAD_DEFAULT (RELOAD_DEFAULT)
    ) u_core (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (i_load),
        .i_data   (i_data),
        .i_reload (w_reload),
        .i_dec    (w_dec),
        .o_count  (w_count)
    );

    assign w_zero = (w_count == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_bout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bout  <= w_bout_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_reload     = 1'b0;
        w_dec        = 1'b0;
        w_bout_next  = 1'b0;
        if (i_load) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        w_state_next = ST_RUN;
                        w_reload     = 1'b1;
                    end
                end
                ST_RUN: begin
                    // START is deliberately ignored here: it never restarts a run.
                    if (i_en) begin
                        if (w_zero) begin
                            w_bout_next = 1'b1;
                            if (i_mode) begin
                                w_reload = 1'b1;
                            end else begin
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_dec = 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign o_dout = w_count;
    assign o_bout = r_bout;
    assign o_zero = w_zero;
    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_down_cnt_timer.sv
// Self-checking bench for down_cnt_timer: directed scenarios plus randomized
// traffic compared against a behavioural model of the timer.
module tb_down_cnt_timer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic       mode  = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data  = 8'd0;
    logic [7:0] o_dout;
    logic       o_bout, o_zero, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: reload value, current count, running/finished flags.
    logic [7:0] m_reload, m_count;
    bit         m_running, m_finished, m_bout;

    down_cnt_timer dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_load  (load),
        .i_data  (data),
        .i_mode  (mode),
        .i_start (start),
        .o_dout  (o_dout),
        .o_bout  (o_bout),
        .o_zero  (o_zero),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_reload   = 8'd255;
        m_count    = 8'd0;
        m_running  = 1'b0;
        m_finished = 1'b0;
        m_bout     = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input bit ld, input logic [7:0] d, input bit md,
                        input bit st, input bit e);
        load = ld; data = d; mode = md; start = st; en = e;
        @(posedge clk);
        m_bout = 1'b0;
        if (ld) begin
            m_reload   = d;
            m_count    = d;
            m_running  = 1'b0;
            m_finished = 1'b0;
        end else if (st && !m_running) begin
            m_count    = m_reload;
            m_running  = 1'b1;
            m_finished = 1'b0;
        end else if (m_running && e) begin
            if (m_count != 0) begin
                m_count = m_count - 8'd1;
            end else begin
                m_bout = 1'b1;
                if (md) begin
                    m_count = m_reload;
                end else begin
                    m_running  = 1'b0;
                    m_finished = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (o_dout !== 8'd0 || o_bout !== 1'b0 || o_zero !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got dout=%0h bout=%b zero=%b busy=%b done=%b, expected 0 0 1 0 0",
                     o_dout, o_bout, o_zero, o_busy, o_done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 8'h40, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        checks++;
        if (o_dout !== 8'h40 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: got dout=%0h busy=%b, expected 40 1", o_dout, o_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_dout !== 8'd0 || o_bout !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: got dout=%0h bout=%b busy=%b done=%b, expected 0 0 0 0",
                     o_dout, o_bout, o_busy, o_done);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'h00, 0, 1, 0);
        checks++;
        if (o_dout !== 8'd255 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_reload_default: got dout=%0h busy=%b, expected ff 1", o_dout, o_busy);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_seq [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
        step(1, 8'd3, 0, 0, 0);
        step(0, 8'd0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_dout !== exp_seq[i] || o_bout !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_count[%0d]: got dout=%0d bout=%b busy=%b, expected %0d 0 1",
                         i, o_dout, o_bout, o_busy, exp_seq[i]);
            end
            step(0, 8'd0, 0, 0, 1);
        end
        checks++;
        if (o_bout !== 1'b1 || o_done !== 1'b1 || o_busy !== 1'b0 || o_dout !== 8'd0) begin
            errors++;
            $display("FAIL oneshot_borrow: got bout=%b done=%b busy=%b dout=%0d, expected 1 1 0 0",
                     o_bout, o_done, o_busy, o_dout);
        end
        step(0, 8'd0, 0, 0, 1);
        checks++;
        if (o_bout !== 1'b0 || o_done !== 1'b1 || o_dout !== 8'd0 || o_zero !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_done_hold: got bout=%b done=%b dout=%0d zero=%b, expected 0 1 0 1",
                     o_bout, o_done, o_dout, o_zero);
        end
    endtask

    task automatic test_autoreload();
        step(1, 8'd2, 1, 0, 1);
        step(0, 8'd0, 1, 1, 1);
        checks++;
        if (o_dout !== 8'd2 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_start: got dout=%0d busy=%b, expected 2 1", o_dout, o_busy);
        end
        for (int k = 1; k <= 9; k++) begin
            logic [7:0] exp_d;
            logic       exp_b;
            step(0, 8'd0, 1, 0, 1);
            exp_d = 8'((2 - (k % 3) + 3) % 3);
            exp_b = ((k % 3) == 0);
            checks++;
            if (o_dout !== exp_d || o_bout !== exp_b || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL auto_cycle[%0d]: got dout=%0d bout=%b busy=%b, expected %0d %b 1",
                         k, o_dout, o_bout, o_busy, exp_d, exp_b);
            end
        end
    endtask

    task automatic test_enable();
        logic       en_pat  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_seq [4] = '{8'd4, 8'd4, 8'd3, 8'd3};
        step(1, 8'd5, 0, 0, 0);
        step(0, 8'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'd0, 0, 0, en_pat[i]);
            checks++;
            if (o_dout !== exp_seq[i] || o_bout !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL enable_gate[%0d]: got dout=%0d bout=%b busy=%b, expected %0d 0 1",
                         i, o_dout, o_bout, o_busy, exp_seq[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        step(1, 8'h10, 0, 1, 1);
        checks++;
        if (o_dout !== 8'h10 || o_busy !== 1'b0 || o_done !== 1'b0 || o_bout !== 1'b0) begin
            errors++;
            $display("FAIL load_over_start: got dout=%0h busy=%b done=%b bout=%b, expected 10 0 0 0",
                     o_dout, o_busy, o_done, o_bout);
        end
        step(0, 8'h00, 0, 0, 1);
        checks++;
        if (o_dout !== 8'h10 || o_busy !== 1'b0 || o_bout !== 1'b0) begin
            errors++;
            $display("FAIL load_idle_hold: got dout=%0h busy=%b bout=%b, expected 10 0 0",
                     o_dout, o_busy, o_bout);
        end
    endtask

    task automatic test_zero_reload();
        step(1, 8'd0, 1, 0, 1);
        step(0, 8'd0, 1, 1, 1);
        checks++;
        if (o_bout !== 1'b0 || o_busy !== 1'b1 || o_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_start: got bout=%b busy=%b zero=%b, expected 0 1 1", o_bout, o_busy, o_zero);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 8'd0, 1, bit'(i % 2), 1);
            checks++;
            if (o_bout !== 1'b1 || o_dout !== 8'd0 || o_zero !== 1'b1 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL zero_continuous[%0d]: got bout=%b dout=%0d zero=%b busy=%b, expected 1 0 1 1",
                         i, o_bout, o_dout, o_zero, o_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit         ld, md, st, e;
            logic [7:0] d;
            ld = ($urandom_range(99) < 6);
            st = ($urandom_range(99) < 15);
            e  = ($urandom_range(99) < 70);
            md = ($urandom_range(99) < 50);
            d  = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(6));
            step(ld, d, md, st, e);
            checks++;
            if (o_dout !== m_count || o_bout !== m_bout || o_zero !== (m_count == 8'd0) ||
                o_busy !== m_running || o_done !== m_finished) begin
                errors++;
                $display("FAIL random[%0d]: got dout=%0d bout=%b zero=%b busy=%b done=%b, expected %0d %b %b %b %b",
                         i, o_dout, o_bout, o_zero, o_busy, o_done,
                         m_count, m_bout, (m_count == 8'd0), m_running, m_finished);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_enable();
        test_load_priority();
        test_zero_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
